// File: rtl/enemy_hp_ctrl.sv
// Hit-point controller for four regular enemies and the boss.
// Converts per-frame collision hits into saturating HP decrements, hit pulses and spawn/despawn sequencing.
module enemy_hp_ctrl #(
  parameter int ENM_HP    = 100,
  parameter int BOSS_HP   = 1000,
  parameter int ENM_DMG   = 1,
  parameter int BOSS_DMG  = 2,
  parameter int IFRAMES   = 3,
  parameter int DEAD_HOLD = 8
) (
  input  logic       clk22,
  input  logic       rst,
  input  logic [3:0] enm_spawn,
  input  logic       boss_spawn,
  input  logic [3:0] hit_enm,
  input  logic       hit_boss,
  output logic [6:0] enmhp1,
  output logic [6:0] enmhp2,
  output logic [6:0] enmhp3,
  output logic [6:0] enmhp4,
  output logic [9:0] bosshp,
  output logic       shot_enm,
  output logic       shot_boss,
  output logic [3:0] enm_alive,
  output logic       boss_alive,
  output logic       stage_clear
);

  typedef enum logic [1:0] {ST_IDLE, ST_ALIVE, ST_HURT, ST_DEAD} state_t;

  localparam logic [6:0] ENM_FULL   = 7'(ENM_HP);
  localparam logic [6:0] ENM_DMG_V  = 7'(ENM_DMG);
  localparam logic [9:0] BOSS_FULL  = 10'(BOSS_HP);
  localparam logic [9:0] BOSS_DMG_V = 10'(BOSS_DMG);
  localparam logic [7:0] ENM_IFR    = 8'(IFRAMES);
  localparam logic [7:0] ENM_HOLD   = 8'(DEAD_HOLD);
  localparam logic [3:0] BOSS_IFR   = 4'(IFRAMES);

  state_t     enm_state [4];
  logic [6:0] enm_hp    [4];
  logic [7:0] enm_cnt   [4];
  logic [3:0] enm_accept;

  state_t     boss_state;
  logic [3:0] boss_cnt;
  logic       boss_accept;

  // A hit only counts while the target is ALIVE; IDLE, HURT and DEAD swallow it.
  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    enm_accept = '0;
    for (int i = 0; i < 4; i++) begin
      enm_accept[i] = (enm_state[i] == ST_ALIVE) && hit_enm[i];
    end
    boss_accept = (boss_state == ST_ALIVE) && hit_boss;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the per-enemy arrays are a handful of flops, not RAM, so they are reset like any other register.
  always_ff @(posedge clk22 or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        enm_state[i] <= ST_IDLE;
        enm_hp[i]    <= ENM_FULL;
        enm_cnt[i]   <= '0;
      end
      enm_alive <= '0;
      shot_enm  <= 1'b0;
    end else begin
      shot_enm <= |enm_accept;
      for (int i = 0; i < 4; i++) begin
        case (enm_state[i])
          ST_IDLE: begin
            enm_hp[i] <= ENM_FULL;
            if (enm_spawn[i]) begin
              enm_state[i] <= ST_ALIVE;
              enm_alive[i] <= 1'b1;
            end
          end
          ST_ALIVE: begin
            if (enm_accept[i]) begin
              if (enm_hp[i] <= ENM_DMG_V) begin
                enm_hp[i]    <= '0;
                enm_state[i] <= ST_DEAD;
                enm_cnt[i]   <= ENM_HOLD;
                enm_alive[i] <= 1'b0;
              end else begin
                enm_hp[i] <= enm_hp[i] - ENM_DMG_V;
                if (IFRAMES != 0) begin
                  enm_state[i] <= ST_HURT;
                  enm_cnt[i]   <= ENM_IFR;
                end
              end
            end
          end
          ST_HURT: begin
            enm_cnt[i] <= enm_cnt[i] - 8'd1;
            if (enm_cnt[i] == 8'd1) enm_state[i] <= ST_ALIVE;
          end
          ST_DEAD: begin
            // Counter reaching zero on this edge re-arms the slot with full HP.
            enm_cnt[i] <= enm_cnt[i] - 8'd1;
            if (enm_cnt[i] == 8'd1) begin
              enm_state[i] <= ST_IDLE;
              enm_hp[i]    <= ENM_FULL;
            end
          end
          default: enm_state[i] <= ST_IDLE;
        endcase
      end
    end
  end

  // Boss: same life cycle, but DEAD is terminal and latches stage_clear until reset.
  always_ff @(posedge clk22 or negedge rst) begin
    if (!rst) begin
      boss_state  <= ST_IDLE;
      bosshp      <= BOSS_FULL;
      boss_cnt    <= '0;
      boss_alive  <= 1'b0;
      shot_boss   <= 1'b0;
      stage_clear <= 1'b0;
    end else begin
      shot_boss <= boss_accept;
      case (boss_state)
        ST_IDLE: begin
          bosshp <= BOSS_FULL;
          if (boss_spawn) begin
            boss_state <= ST_ALIVE;
            boss_alive <= 1'b1;
          end
        end
        ST_ALIVE: begin
          if (boss_accept) begin
            if (bosshp <= BOSS_DMG_V) begin
              bosshp      <= '0;
              boss_state  <= ST_DEAD;
              boss_alive  <= 1'b0;
              stage_clear <= 1'b1;
            end else begin
              bosshp <= bosshp - BOSS_DMG_V;
              if (IFRAMES != 0) begin
                boss_state <= ST_HURT;
                boss_cnt   <= BOSS_IFR;
              end
            end
          end
        end
        ST_HURT: begin
          boss_cnt <= boss_cnt - 4'd1;
          if (boss_cnt == 4'd1) boss_state <= ST_ALIVE;
        end
        ST_DEAD: begin
          bosshp <= '0;
        end
        default: boss_state <= ST_IDLE;
      endcase
    end
  end

  assign enmhp1 = enm_hp[0];
  assign enmhp2 = enm_hp[1];
  assign enmhp3 = enm_hp[2];
  assign enmhp4 = enm_hp[3];

endmodule

// File: tb/tb_enemy_hp_ctrl.sv
// Self-checking bench for enemy_hp_ctrl: vector table, directed kill/boss/reset sequences,
// and random stimulus against a deadline-based reference model.
module tb_enemy_hp_ctrl;

  localparam int ENM_HP    = 100;
  localparam int BOSS_HP   = 1000;
  localparam int ENM_DMG   = 1;
  localparam int BOSS_DMG  = 2;
  localparam int IFRAMES   = 3;
  localparam int DEAD_HOLD = 8;

  logic       clk22 = 1'b0;
  logic       rst   = 1'b0;
  logic [3:0] enm_spawn = '0, hit_enm = '0;
  logic       boss_spawn = 1'b0, hit_boss = 1'b0;
  logic [6:0] enmhp1, enmhp2, enmhp3, enmhp4;
  logic [9:0] bosshp;
  logic       shot_enm, shot_boss, boss_alive, stage_clear;
  logic [3:0] enm_alive;

  // Second instance with a tiny boss for the saturation / stage-clear sequence.
  logic       b_spawn = 1'b0, b_hit = 1'b0;
  logic [6:0] b_hp1, b_hp2, b_hp3, b_hp4;
  logic [9:0] b_bosshp;
  logic       b_shot_enm, b_shot_boss, b_boss_alive, b_stage_clear;
  logic [3:0] b_enm_alive;

  enemy_hp_ctrl #(.ENM_HP(ENM_HP), .BOSS_HP(BOSS_HP), .ENM_DMG(ENM_DMG), .BOSS_DMG(BOSS_DMG),
                  .IFRAMES(IFRAMES), .DEAD_HOLD(DEAD_HOLD)) dut (
    .clk22(clk22), .rst(rst), .enm_spawn(enm_spawn), .boss_spawn(boss_spawn),
    .hit_enm(hit_enm), .hit_boss(hit_boss),
    .enmhp1(enmhp1), .enmhp2(enmhp2), .enmhp3(enmhp3), .enmhp4(enmhp4), .bosshp(bosshp),
    .shot_enm(shot_enm), .shot_boss(shot_boss), .enm_alive(enm_alive),
    .boss_alive(boss_alive), .stage_clear(stage_clear));

  enemy_hp_ctrl #(.BOSS_HP(3), .BOSS_DMG(2)) dut_b (
    .clk22(clk22), .rst(rst), .enm_spawn(4'b0000), .boss_spawn(b_spawn),
    .hit_enm(4'b0000), .hit_boss(b_hit),
    .enmhp1(b_hp1), .enmhp2(b_hp2), .enmhp3(b_hp3), .enmhp4(b_hp4), .bosshp(b_bosshp),
    .shot_enm(b_shot_enm), .shot_boss(b_shot_boss), .enm_alive(b_enm_alive),
    .boss_alive(b_boss_alive), .stage_clear(b_stage_clear));

  always #5 clk22 = ~clk22;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: absolute edge numbers at which an enemy may be hit again or re-arms.
  int cyc;
  int m_hp [4];
  bit m_alive [4];
  int m_free_at [4];
  int m_rearm_at [4];
  int m_bhp, m_bfree_at;
  bit m_balive, m_clear, m_shot_e, m_shot_b;

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      m_hp[i] = ENM_HP; m_alive[i] = 0; m_free_at[i] = 0; m_rearm_at[i] = 0;
    end
    m_bhp = BOSS_HP; m_bfree_at = 0; m_balive = 0; m_clear = 0;
    m_shot_e = 0; m_shot_b = 0;
  endtask

  task automatic model_edge(input logic [3:0] sp, input logic bs, input logic [3:0] h, input logic bh);
    bit acc;
    cyc++;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_hp[i] == 0) begin
        if (cyc >= m_rearm_at[i]) m_hp[i] = ENM_HP;
      end else if (!m_alive[i]) begin
        if (sp[i]) m_alive[i] = 1;
      end else if (h[i] && cyc >= m_free_at[i]) begin
        acc = 1;
        m_hp[i] = (m_hp[i] > ENM_DMG) ? m_hp[i] - ENM_DMG : 0;
        if (m_hp[i] == 0) begin
          m_alive[i] = 0;
          m_rearm_at[i] = cyc + DEAD_HOLD;
        end else begin
          m_free_at[i] = cyc + IFRAMES + 1;
        end
      end
    end
    m_shot_e = acc;
    m_shot_b = 0;
    if (!m_clear) begin
      if (!m_balive) begin
        if (bs) m_balive = 1;
      end else if (bh && cyc >= m_bfree_at) begin
        m_shot_b = 1;
        m_bhp = (m_bhp > BOSS_DMG) ? m_bhp - BOSS_DMG : 0;
        if (m_bhp == 0) begin
          m_balive = 0;
          m_clear = 1;
        end else begin
          m_bfree_at = cyc + IFRAMES + 1;
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [3:0] exp_alive;
    for (int i = 0; i < 4; i++) exp_alive[i] = m_alive[i];
    check({tag, " enmhp1"}, enmhp1, m_hp[0]);
    check({tag, " enmhp2"}, enmhp2, m_hp[1]);
    check({tag, " enmhp3"}, enmhp3, m_hp[2]);
    check({tag, " enmhp4"}, enmhp4, m_hp[3]);
    check({tag, " bosshp"}, bosshp, m_bhp);
    check({tag, " shot_enm"}, shot_enm, m_shot_e);
    check({tag, " shot_boss"}, shot_boss, m_shot_b);
    check({tag, " enm_alive"}, enm_alive, exp_alive);
    check({tag, " boss_alive"}, boss_alive, m_balive);
    check({tag, " stage_clear"}, stage_clear, m_clear);
  endtask

  task automatic step(input logic [3:0] sp, input logic bs, input logic [3:0] h, input logic bh,
                      input string tag);
    enm_spawn = sp; boss_spawn = bs; hit_enm = h; hit_boss = bh;
    @(posedge clk22);
    model_edge(sp, bs, h, bh);
    #1;
    compare_model(tag);
  endtask

  typedef struct {
    logic [3:0] spawn;
    logic       bsp;
    logic [3:0] hit;
    logic       bhit;
    int         hp1, hp2, bhp;
    logic       se, sb;
    logic [3:0] alive;
    logic       balive;
  } vec_t;

  vec_t vecs [18];

  initial begin
    // spawn  bsp  hit    bhit  hp1  hp2  bhp   se  sb  alive   balive
    vecs[0]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 100, 100, 1000, 1'b0, 1'b0, 4'b0001, 1'b0};
    vecs[1]  = '{4'b0000, 1'b0, 4'b0001, 1'b0,  99, 100, 1000, 1'b1, 1'b0, 4'b0001, 1'b0};
    vecs[2]  = '{4'b0000, 1'b0, 4'b0001, 1'b0,  99, 100, 1000, 1'b0, 1'b0, 4'b0001, 1'b0};
    vecs[3]  = '{4'b0000, 1'b0, 4'b0001, 1'b0,  99, 100, 1000, 1'b0, 1'b0, 4'b0001, 1'b0};
    vecs[4]  = '{4'b0000, 1'b0, 4'b0001, 1'b0,  99, 100, 1000, 1'b0, 1'b0, 4'b0001, 1'b0};
    vecs[5]  = '{4'b0000, 1'b0, 4'b0001, 1'b0,  98, 100, 1000, 1'b1, 1'b0, 4'b0001, 1'b0};
    vecs[6]  = '{4'b0000, 1'b0, 4'b0110, 1'b0,  98, 100, 1000, 1'b0, 1'b0, 4'b0001, 1'b0};
    vecs[7]  = '{4'b1110, 1'b0, 4'b0010, 1'b0,  98, 100, 1000, 1'b0, 1'b0, 4'b1111, 1'b0};
    vecs[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b0,  98, 100, 1000, 1'b0, 1'b0, 4'b1111, 1'b0};
    vecs[9]  = '{4'b0000, 1'b0, 4'b1111, 1'b0,  97,  99, 1000, 1'b1, 1'b0, 4'b1111, 1'b0};
    vecs[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0,  97,  99, 1000, 1'b0, 1'b0, 4'b1111, 1'b0};
    vecs[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1,  97,  99, 1000, 1'b0, 1'b0, 4'b1111, 1'b1};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1,  97,  99,  998, 1'b0, 1'b1, 4'b1111, 1'b1};
    vecs[13] = '{4'b0000, 1'b0, 4'b0010, 1'b1,  97,  98,  998, 1'b1, 1'b0, 4'b1111, 1'b1};
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0,  97,  98,  998, 1'b0, 1'b0, 4'b1111, 1'b1};
    vecs[15] = '{4'b0000, 1'b0, 4'b0000, 1'b1,  97,  98,  998, 1'b0, 1'b0, 4'b1111, 1'b1};
    vecs[16] = '{4'b0000, 1'b0, 4'b0001, 1'b1,  96,  98,  996, 1'b1, 1'b1, 4'b1111, 1'b1};
    vecs[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0,  96,  98,  996, 1'b0, 1'b0, 4'b1111, 1'b1};

    model_reset();
    #12 rst = 1'b1;
    for (int n = 0; n < 10; n++) step(4'b0000, 1'b0, 4'b0000, 1'b0, "idle");
    check("reset enmhp1", enmhp1, 100);
    check("reset enmhp4", enmhp4, 100);
    check("reset bosshp", bosshp, 1000);
    check("reset shots", {shot_enm, shot_boss}, 0);
    check("reset enm_alive", enm_alive, 0);
    check("reset stage_clear", stage_clear, 0);

    for (int r = 0; r < 18; r++) begin
      step(vecs[r].spawn, vecs[r].bsp, vecs[r].hit, vecs[r].bhit, "vec");
      check($sformatf("vec%0d enmhp1", r), enmhp1, vecs[r].hp1);
      check($sformatf("vec%0d enmhp2", r), enmhp2, vecs[r].hp2);
      check($sformatf("vec%0d bosshp", r), bosshp, vecs[r].bhp);
      check($sformatf("vec%0d shot_enm", r), shot_enm, vecs[r].se);
      check($sformatf("vec%0d shot_boss", r), shot_boss, vecs[r].sb);
      check($sformatf("vec%0d enm_alive", r), enm_alive, vecs[r].alive);
      check($sformatf("vec%0d boss_alive", r), boss_alive, vecs[r].balive);
    end

    // Wear enemy 2 down to HP 1, then kill it and watch the dead hold.
    for (int n = 0; n < 600 && m_hp[1] != 1; n++) step(4'b0000, 1'b0, 4'b0010, 1'b0, "wear e2");
    check("e2 at hp1", enmhp2, 1);
    for (int n = 0; n < 3; n++) step(4'b0000, 1'b0, 4'b0000, 1'b0, "e2 hurt");
    step(4'b0000, 1'b0, 4'b0010, 1'b0, "e2 kill");
    check("kill enmhp2", enmhp2, 0);
    check("kill shot_enm", shot_enm, 1);
    check("kill alive2", enm_alive[1], 0);
    for (int n = 1; n < DEAD_HOLD; n++) begin
      step(4'b0010, 1'b0, 4'b0010, 1'b0, "e2 dead");
      check($sformatf("dead%0d enmhp2", n), enmhp2, 0);
      check($sformatf("dead%0d shot_enm", n), shot_enm, 0);
    end
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "e2 rearm");
    check("rearm enmhp2", enmhp2, 100);
    check("rearm alive2", enm_alive[1], 0);

    // Small boss on the second instance: 3 -> 1 -> 0 (saturated), stage_clear latches.
    b_spawn = 1'b1;
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "bb");
    check("bb spawn hp", b_bosshp, 3);
    check("bb spawn alive", b_boss_alive, 1);
    b_spawn = 1'b0; b_hit = 1'b1;
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "bb");
    check("bb hit1 hp", b_bosshp, 1);
    check("bb hit1 shot", b_shot_boss, 1);
    for (int n = 0; n < IFRAMES; n++) begin
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "bb");
      check($sformatf("bb iframe%0d hp", n), b_bosshp, 1);
      check($sformatf("bb iframe%0d shot", n), b_shot_boss, 0);
    end
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "bb");
    check("bb kill hp", b_bosshp, 0);
    check("bb kill shot", b_shot_boss, 1);
    check("bb kill clear", b_stage_clear, 1);
    check("bb kill alive", b_boss_alive, 0);
    b_hit = 1'b0; b_spawn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "bb");
      check($sformatf("bb respawn%0d hp", n), b_bosshp, 0);
      check($sformatf("bb respawn%0d alive", n), b_boss_alive, 0);
      check($sformatf("bb respawn%0d clear", n), b_stage_clear, 1);
      check($sformatf("bb respawn%0d shot", n), b_shot_boss, 0);
    end
    b_spawn = 1'b0;
    check("bb enemies idle", {b_enm_alive, b_shot_enm}, 0);
    check("bb enemy hp", b_hp1 + b_hp2 + b_hp3 + b_hp4, 4 * ENM_HP);

    // Drive enemy 1 to HP 57 (ends in HURT), then pull reset between edges.
    for (int n = 0; n < 400 && m_hp[0] != 57; n++) step(4'b0000, 1'b0, 4'b0001, 1'b0, "wear e1");
    check("e1 at hp57", enmhp1, 57);
    check("e1 hit pulse", shot_enm, 1);
    #2 rst = 1'b0;
    #1;
    check("async rst enmhp1", enmhp1, 100);
    check("async rst enmhp2", enmhp2, 100);
    check("async rst bosshp", bosshp, 1000);
    check("async rst shot_enm", shot_enm, 0);
    check("async rst enm_alive", enm_alive, 0);
    check("async rst boss_alive", boss_alive, 0);
    check("async rst b_clear", b_stage_clear, 0);
    check("async rst b_bosshp", b_bosshp, 3);
    model_reset();
    @(negedge clk22);
    rst = 1'b1;

    for (int n = 0; n < 4000; n++) begin
      logic [3:0] sp;
      for (int i = 0; i < 4; i++) sp[i] = ($urandom_range(7) == 0);
      step(sp, ($urandom_range(15) == 0), 4'($urandom()), ($urandom_range(1) == 1), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
